fifo_stream_reader: RTL and testbench

- Consumer for the read port of the team's synchronous FIFO (`i_rd_en` / `o_rd_empty` / `o_rd_data` side).
- Pops words from the FIFO and presents them on a valid/ready output stream.
- A 2-entry skid buffer absorbs the FIFO's one-cycle read latency, giving one word per clock in steady state.
- Frames the stream into packets of PKT_LEN words, marking the last word of each packet with `o_last`.

---
 rtl/fifo_stream_reader_if.sv | 15 +
 rtl/fifo_stream_reader.sv | 47 ++++
 tb/tb_fifo_stream_reader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read-port signals plus the framed valid/ready output stream
//   master: the reader (drives o_rd_en, o_data, o_valid, o_last)
//   slave : the environment (drives i_enable, i_rd_empty, i_rd_data, i_ready)
interface fifo_stream_reader_if #(parameter int DATAW = 8);
  logic             i_enable;
  logic             i_rd_empty;
  logic [DATAW-1:0] i_rd_data;
  logic             o_rd_en;
  logic [DATAW-1:0] o_data;
  logic             o_valid;
  logic             i_ready;
  logic             o_last;
  modport master(input i_enable, i_rd_empty, i_rd_data, i_ready, output o_rd_en, o_data, o_valid, o_last);
  modport slave(output i_enable, i_rd_empty, i_rd_data, i_ready, input o_rd_en, o_data, o_valid, o_last);
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a synchronous FIFO through a 2-entry skid buffer onto a packetised valid/ready stream
//   clk, rst_n (async, active low)
//   bus.i_enable / i_rd_empty / i_rd_data -> o_rd_en : FIFO read side, data one cycle after the read
//   bus.o_data / o_valid / o_last <- i_ready         : output stream, o_last on every PKT_LEN-th word
module fifo_stream_reader #(
  parameter int DATAW   = 8,
  parameter int PKT_LEN = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  fifo_stream_reader_if.master bus
);
  localparam int PW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PKT_LEN - 1);
  logic [DATAW-1:0] head, tail;
  logic [1:0]       occ;
  logic             infl;
  logic [PW-1:0]    pcnt;
  logic             pop;
  assign pop = bus.o_valid & bus.i_ready;
  // A pop frees a slot on the same edge, so a full buffer can still issue a read while draining.
  always_comb begin
    bus.o_valid = occ != 2'd0;
    bus.o_data  = head;
    bus.o_last  = bus.o_valid & (pcnt == PLAST);
    bus.o_rd_en = rst_n & bus.i_enable & ~bus.i_rd_empty & ((occ + {1'b0, infl} < 2'd2) | pop);
  end
  // Returning FIFO data lands at the head when it becomes the only entry, otherwise at the tail.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
      infl <= 1'b0;
      pcnt <= '0;
    end else begin
      infl <= bus.o_rd_en;
      occ  <= occ + {1'b0, infl} - {1'b0, pop};
      head <= pop ? (occ == 2'd2 ? tail : (infl ? bus.i_rd_data : head))
                  : (occ == 2'd0 && infl ? bus.i_rd_data : head);
      tail <= infl && occ == (pop ? 2'd2 : 2'd1) ? bus.i_rd_data : tail;
      if (pop) pcnt <= pcnt == PLAST ? '0 : pcnt + 1'b1;
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) ({1'b0, occ} + {2'b0, infl}) <= 3'd2);
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    bus.o_valid && !bus.i_ready |=> bus.o_valid && $stable(bus.o_data) && $stable(bus.o_last));
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized and directed check of fifo_stream_reader against a queue-based model
module tb_fifo_stream_reader;
  localparam int DATAW = 8;
  localparam int PKT_LEN = 4;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  fifo_stream_reader_if #(.DATAW(DATAW)) bus();
  fifo_stream_reader #(.DATAW(DATAW), .PKT_LEN(PKT_LEN)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0, n_bad = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_d[$];
  logic       got_l[$];
  int         got_c[$];
  int held = 0, last_rd = 0, pk = 0, cyc = 0, n_rd = 0, n_xfer = 0;
  int b_rd, b_x;
  logic rd_s = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic chk_got(input string nm, input int idx, input logic [7:0] d, input logic l);
    chk({nm, "_data"}, 32'(got_d[idx]), 32'(d));
    chk({nm, "_last"}, 32'(got_l[idx]), 32'(l));
  endtask
  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    bus.i_rd_empty = 1'b0;
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  // FIFO read port: a read accepted at an edge returns its word just after that edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      fifo_q.delete();
      bus.i_rd_data = '0;
    end else if (rd_s && fifo_q.size() > 0) bus.i_rd_data = fifo_q.pop_front();
    bus.i_rd_empty = fifo_q.size() == 0;
  end
  // Model: held = words read but not yet delivered; a word read at the last edge is still in flight.
  always @(negedge clk) begin : cmp
    logic xfer, ev, er;
    if (!rst_n) begin
      exp_q.delete();
      held = 0;
      last_rd = 0;
      pk = 0;
      rd_s = 1'b0;
    end else begin
      cyc++;
      ev = (held - last_rd) > 0;
      er = bus.i_enable && !bus.i_rd_empty && (held < 2 || (bus.o_valid && bus.i_ready));
      chk("o_valid", 32'(bus.o_valid), 32'(ev));
      chk("o_rd_en", 32'(bus.o_rd_en), 32'(er));
      xfer = bus.o_valid && bus.i_ready;
      if (bus.o_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_word: got %0h expected no word", bus.o_data);
        end else begin
          chk("o_data", 32'(bus.o_data), 32'(exp_q[0]));
          chk("o_last", 32'(bus.o_last), 32'(pk == PKT_LEN - 1));
        end
      end else chk("o_last_idle", 32'(bus.o_last), 32'(0));
      if (xfer) begin
        got_d.push_back(bus.o_data);
        got_l.push_back(bus.o_last);
        got_c.push_back(cyc);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pk = (pk + 1) % PKT_LEN;
        n_xfer++;
      end
      if (bus.o_rd_en) n_rd++;
      held = held + int'(bus.o_rd_en) - int'(xfer);
      last_rd = int'(bus.o_rd_en);
      rd_s = bus.o_rd_en;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    bus.i_enable = 1'b1;
    bus.i_ready = 1'b1;
    bus.i_rd_empty = 1'b0;
    bus.i_rd_data = '0;
    #3;
    chk("rst_valid", 32'(bus.o_valid), 32'(0));
    chk("rst_last", 32'(bus.o_last), 32'(0));
    chk("rst_data", 32'(bus.o_data), 32'(0));
    chk("rst_rd_en", 32'(bus.o_rd_en), 32'(0));
    bus.i_enable = 1'b0;
    bus.i_ready = 1'b0;
    #20 rst_n = 1'b1;
    step;
    // back-to-back stream of one packet
    b_rd = n_rd; b_x = n_xfer;
    bus.i_ready = 1'b1;
    bus.i_enable = 1'b1;
    for (int i = 1; i <= 4; i++) push(8'(i));
    repeat (10) step;
    chk("t1_reads", 32'(n_rd - b_rd), 32'(4));
    chk("t1_count", 32'(n_xfer - b_x), 32'(4));
    for (int k = 0; k < 4; k++) chk_got("t1", b_x + k, 8'(k + 1), k == 3);
    chk("t1_back2back", 32'(got_c[b_x + 3] - got_c[b_x]), 32'(3));
    // downstream stalled: only two reads, head held
    b_rd = n_rd; b_x = n_xfer;
    bus.i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    repeat (10) step;
    chk("t2_reads", 32'(n_rd - b_rd), 32'(2));
    chk("t2_valid", 32'(bus.o_valid), 32'(1));
    chk("t2_hold", 32'(bus.o_data), 32'(1));
    chk("t2_none", 32'(n_xfer - b_x), 32'(0));
    bus.i_ready = 1'b1;
    repeat (10) step;
    chk("t2_count", 32'(n_xfer - b_x), 32'(4));
    for (int k = 0; k < 4; k++) chk_got("t2", b_x + k, 8'(k + 1), k == 3);
    // packet wrap across a five-word burst
    b_x = n_xfer;
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
    repeat (12) step;
    for (int k = 0; k < 5; k++) chk_got("t3", b_x + k, 8'(8'hA0 + k), k == 3);
    repeat (3) step;
    push(8'hA5);
    repeat (6) step;
    chk_got("t3_a5", b_x + 5, 8'hA5, 1'b0);
    // enable dropped right after the first read
    bus.i_enable = 1'b0;
    b_rd = n_rd; b_x = n_xfer;
    push(8'hB0); push(8'hB1); push(8'hB2);
    repeat (3) step;
    chk("t4_idle_reads", 32'(n_rd - b_rd), 32'(0));
    bus.i_enable = 1'b1;
    step;
    bus.i_enable = 1'b0;
    repeat (8) step;
    chk("t4_reads", 32'(n_rd - b_rd), 32'(1));
    chk("t4_count", 32'(n_xfer - b_x), 32'(1));
    chk("t4_no_rd", 32'(bus.o_rd_en), 32'(0));
    chk_got("t4_b0", b_x, 8'hB0, 1'b0);
    bus.i_enable = 1'b1;
    repeat (10) step;
    chk_got("t4_b1", b_x + 1, 8'hB1, 1'b1);
    chk_got("t4_b2", b_x + 2, 8'hB2, 1'b0);
    // asynchronous reset mid-stream after word 2
    b_x = n_xfer;
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    for (int k = 0; k < 40 && n_xfer - b_x < 2; k++) step;
    chk("t5_reached", 32'(n_xfer - b_x), 32'(2));
    #1 rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(bus.o_valid), 32'(0));
    chk("t5_last", 32'(bus.o_last), 32'(0));
    chk("t5_rd_en", 32'(bus.o_rd_en), 32'(0));
    chk("t5_data", 32'(bus.o_data), 32'(0));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    b_x = n_xfer;
    step;
    push(8'd7); push(8'd8);
    repeat (8) step;
    chk_got("t5_7", b_x, 8'd7, 1'b0);
    chk_got("t5_8", b_x + 1, 8'd8, 1'b0);
    push(8'd9); push(8'd10);
    repeat (8) step;
    chk_got("t5_9", b_x + 2, 8'd9, 1'b0);
    chk_got("t5_10", b_x + 3, 8'd10, 1'b1);
    chk("t5_count", 32'(n_xfer - b_x), 32'(4));
    // random backpressure and enable over 64 words
    b_x = n_xfer;
    for (int i = 0; i < 64; i++) push(8'(i));
    for (int k = 0; k < 3000 && exp_q.size() > 0; k++) begin
      bus.i_ready = 1'($urandom_range(0, 1));
      bus.i_enable = $urandom_range(0, 9) != 0;
      step;
    end
    bus.i_ready = 1'b1;
    bus.i_enable = 1'b1;
    repeat (4) step;
    chk("t6_count", 32'(n_xfer - b_x), 32'(64));
    chk("t6_drained", 32'(exp_q.size()), 32'(0));
    for (int i = 0; i < 64; i++) chk_got("t6", b_x + i, 8'(i), (i % 4) == 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
